core_context_swapper: RTL and testbench

Executes the thread exchange requested by the hardware scheduler: on a swap request it stalls both cores and exchanges all architectural registers x1–x31 between the out-of-order core's retirement register file and the pipelined core's register file. It then redirects each core's fetch PC to the other core's captured PC and reports completion. It sits between the scheduler's `swap_pc` output and the two cores' register-file and PC-redirect ports.

---
 rtl/rv32i_types.sv | 14 +
 rtl/core_context_swapper.sv | 138 +++++++++++++
 tb/tb_core_context_swapper.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the heterogeneous-core context swapper.
package rv32i_types;

  localparam int ARCH_REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    SWAP,
    LAST,
    REDIRECT,
    DONE
  } swap_state_t;

endpackage

// File: rtl/core_context_swapper.sv
// Exchanges x1..x31 and fetch PCs between the OOO core and the pipelined core
// on a scheduler swap request, stalling both cores while it runs.
module core_context_swapper
  import rv32i_types::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       swap_req,
  input  logic [XLEN-1:0]            ooo_pc,
  input  logic [XLEN-1:0]            ppl_pc,
  output logic [ARCH_REG_ADDR_W-1:0] ooo_rf_raddr,
  output logic [ARCH_REG_ADDR_W-1:0] ppl_rf_raddr,
  input  logic [XLEN-1:0]            ooo_rf_rdata,
  input  logic [XLEN-1:0]            ppl_rf_rdata,
  output logic                       ooo_rf_we,
  output logic                       ppl_rf_we,
  output logic [ARCH_REG_ADDR_W-1:0] ooo_rf_waddr,
  output logic [ARCH_REG_ADDR_W-1:0] ppl_rf_waddr,
  output logic [XLEN-1:0]            ooo_rf_wdata,
  output logic [XLEN-1:0]            ppl_rf_wdata,
  output logic                       ooo_pc_load,
  output logic                       ppl_pc_load,
  output logic [XLEN-1:0]            ooo_pc_next,
  output logic [XLEN-1:0]            ppl_pc_next,
  output logic                       stall_cores,
  output logic                       swap_busy,
  output logic                       swap_done,
  output logic                       thread_on_ooo,
  output logic [CNT_W-1:0]           swap_count
);

  localparam logic [ARCH_REG_ADDR_W-1:0] LAST_IDX = ARCH_REG_ADDR_W'(NUM_REGS - 1);

  swap_state_t                state_q, state_d;
  logic [ARCH_REG_ADDR_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]            pc_ooo_q, pc_ppl_q;
  logic                       busy_q;
  logic                       thread_q;
  logic [CNT_W-1:0]           swap_count_q;

  logic                       rd_en;
  logic                       wr_en;
  logic [ARCH_REG_ADDR_W-1:0] waddr;
  logic                       pc_load;
  logic                       done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      thread_q     <= 1'b0;
      swap_count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
      if (state_q == DONE) begin
        thread_q <= ~thread_q;
        if (swap_count_q != '1) swap_count_q <= swap_count_q + 1'b1;
      end
    end
  end

  // Captured PCs stay put for the whole swap; only a fresh acceptance reloads them.
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && swap_req) begin
      pc_ooo_q <= ooo_pc;
      pc_ppl_q <= ppl_pc;
    end
  end

  // Read of x[idx] and write of x[idx-1] overlap, so each register is read in
  // both files one cycle before either file overwrites it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    waddr   = '0;
    pc_load = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req) begin
          state_d = SWAP;
          idx_d   = ARCH_REG_ADDR_W'(1);
        end
      end
      SWAP: begin
        rd_en = 1'b1;
        if (idx_q > ARCH_REG_ADDR_W'(1)) begin
          wr_en = 1'b1;
          waddr = idx_q - 1'b1;
        end
        if (idx_q == LAST_IDX) state_d = LAST;
        else                   idx_d   = idx_q + 1'b1;
      end
      LAST: begin
        wr_en   = 1'b1;
        waddr   = LAST_IDX;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        pc_load = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ooo_rf_raddr  = rd_en ? idx_q : '0;
  assign ppl_rf_raddr  = rd_en ? idx_q : '0;
  assign ooo_rf_we     = wr_en;
  assign ppl_rf_we     = wr_en;
  assign ooo_rf_waddr  = waddr;
  assign ppl_rf_waddr  = waddr;
  assign ooo_rf_wdata  = wr_en ? ppl_rf_rdata : '0;
  assign ppl_rf_wdata  = wr_en ? ooo_rf_rdata : '0;
  assign ooo_pc_load   = pc_load;
  assign ppl_pc_load   = pc_load;
  assign ooo_pc_next   = pc_load ? pc_ppl_q : '0;
  assign ppl_pc_next   = pc_load ? pc_ooo_q : '0;
  assign swap_busy     = busy_q;
  assign stall_cores   = busy_q;
  assign swap_done     = done;
  assign thread_on_ooo = thread_q;
  assign swap_count    = swap_count_q;

endmodule

// File: tb/tb_core_context_swapper.sv
// Bench for core_context_swapper: two register-file models, a phase-based
// reference model checked every cycle, and directed swap scenarios.
module tb_core_context_swapper;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             swap_req = 1'b0;
  logic [XLEN-1:0]  ooo_pc = '0;
  logic [XLEN-1:0]  ppl_pc = '0;
  logic [4:0]       ooo_rf_raddr, ppl_rf_raddr;
  logic [XLEN-1:0]  ooo_rf_rdata, ppl_rf_rdata;
  logic             ooo_rf_we, ppl_rf_we;
  logic [4:0]       ooo_rf_waddr, ppl_rf_waddr;
  logic [XLEN-1:0]  ooo_rf_wdata, ppl_rf_wdata;
  logic             ooo_pc_load, ppl_pc_load;
  logic [XLEN-1:0]  ooo_pc_next, ppl_pc_next;
  logic             stall_cores, swap_busy, swap_done, thread_on_ooo;
  logic [CNT_W-1:0] swap_count;

  logic [XLEN-1:0]  ooo_mem [NUM_REGS];
  logic [XLEN-1:0]  ppl_mem [NUM_REGS];
  logic             load_files = 1'b0;

  int checks   = 0;
  int failures = 0;

  core_context_swapper #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .swap_req(swap_req),
    .ooo_pc(ooo_pc), .ppl_pc(ppl_pc),
    .ooo_rf_raddr(ooo_rf_raddr), .ppl_rf_raddr(ppl_rf_raddr),
    .ooo_rf_rdata(ooo_rf_rdata), .ppl_rf_rdata(ppl_rf_rdata),
    .ooo_rf_we(ooo_rf_we), .ppl_rf_we(ppl_rf_we),
    .ooo_rf_waddr(ooo_rf_waddr), .ppl_rf_waddr(ppl_rf_waddr),
    .ooo_rf_wdata(ooo_rf_wdata), .ppl_rf_wdata(ppl_rf_wdata),
    .ooo_pc_load(ooo_pc_load), .ppl_pc_load(ppl_pc_load),
    .ooo_pc_next(ooo_pc_next), .ppl_pc_next(ppl_pc_next),
    .stall_cores(stall_cores), .swap_busy(swap_busy), .swap_done(swap_done),
    .thread_on_ooo(thread_on_ooo), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  // Core register files: synchronous read, optional bulk preload of the test pattern.
  always @(posedge clk) begin
    if (load_files) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        ooo_mem[i] <= (i == 0) ? 32'hDEAD : 32'h1000 + i;
        ppl_mem[i] <= (i == 0) ? 32'hDEAD : 32'h2000 + i;
      end
    end else begin
      if (ooo_rf_we) ooo_mem[ooo_rf_waddr] <= ooo_rf_wdata;
      if (ppl_rf_we) ppl_mem[ppl_rf_waddr] <= ppl_rf_wdata;
    end
    ooo_rf_rdata <= ooo_mem[ooo_rf_raddr];
    ppl_rf_rdata <= ppl_mem[ppl_rf_raddr];
  end

  // Reference model: m_phase is the number of cycles since acceptance (0 = idle).
  int               m_phase = 0;
  logic [XLEN-1:0]  m_pc_ooo, m_pc_ppl;
  logic [XLEN-1:0]  snap_ooo [NUM_REGS];
  logic [XLEN-1:0]  snap_ppl [NUM_REGS];
  logic             m_thread = 1'b0;
  logic [CNT_W-1:0] m_count = '0;
  logic             model_valid = 1'b0;
  logic             preload_count = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase     <= 0;
      m_thread    <= 1'b0;
      m_count     <= '0;
      model_valid <= 1'b1;
    end else begin
      if (preload_count) m_count <= '1;
      if (m_phase == 0) begin
        if (swap_req) begin
          m_phase  <= 1;
          m_pc_ooo <= ooo_pc;
          m_pc_ppl <= ppl_pc;
          for (int i = 0; i < NUM_REGS; i++) begin
            snap_ooo[i] <= ooo_mem[i];
            snap_ppl[i] <= ppl_mem[i];
          end
        end
      end else if (m_phase == 34) begin
        m_phase  <= 0;
        m_thread <= ~m_thread;
        if (m_count != '1) m_count <= m_count + 1'b1;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_cycle();
    int          p;
    logic        rd, wr;
    logic [31:0] ra, wa, wd_ooo, wd_ppl, pn_ooo, pn_ppl;
    p      = m_phase;
    rd     = (p >= 1 && p <= 31);
    wr     = (p >= 2 && p <= 32);
    ra     = '0;
    wa     = '0;
    wd_ooo = '0;
    wd_ppl = '0;
    pn_ooo = '0;
    pn_ppl = '0;
    if (rd) ra = 32'(p);
    if (wr) begin
      wa     = 32'(p - 1);
      wd_ooo = snap_ppl[p-1];
      wd_ppl = snap_ooo[p-1];
    end
    if (p == 33) begin
      pn_ooo = m_pc_ppl;
      pn_ppl = m_pc_ooo;
    end
    check_output("swap_busy",     32'(swap_busy),     32'(p != 0));
    check_output("stall_cores",   32'(stall_cores),   32'(p != 0));
    check_output("ooo_rf_raddr",  32'(ooo_rf_raddr),  ra);
    check_output("ppl_rf_raddr",  32'(ppl_rf_raddr),  ra);
    check_output("ooo_rf_we",     32'(ooo_rf_we),     32'(wr));
    check_output("ppl_rf_we",     32'(ppl_rf_we),     32'(wr));
    check_output("ooo_rf_waddr",  32'(ooo_rf_waddr),  wa);
    check_output("ppl_rf_waddr",  32'(ppl_rf_waddr),  wa);
    check_output("ooo_rf_wdata",  ooo_rf_wdata,       wd_ooo);
    check_output("ppl_rf_wdata",  ppl_rf_wdata,       wd_ppl);
    check_output("ooo_pc_load",   32'(ooo_pc_load),   32'(p == 33));
    check_output("ppl_pc_load",   32'(ppl_pc_load),   32'(p == 33));
    check_output("ooo_pc_next",   ooo_pc_next,        pn_ooo);
    check_output("ppl_pc_next",   ppl_pc_next,        pn_ppl);
    check_output("swap_done",     32'(swap_done),     32'(p == 34));
    check_output("thread_on_ooo", 32'(thread_on_ooo), 32'(m_thread));
    check_output("swap_count",    32'(swap_count),    32'(m_count));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) compare_cycle();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reload_files();
    load_files = 1'b1;
    step();
    load_files = 1'b0;
    step();
  endtask

  // One pulsed request; reports cycle of swap_done and of the PC redirect.
  task automatic apply_stimulus(output int latency, output int load_cyc,
                                output logic [31:0] pn_ooo, output logic [31:0] pn_ppl);
    latency  = -1;
    load_cyc = -1;
    pn_ooo   = '0;
    pn_ppl   = '0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ooo_pc_load) begin
        load_cyc = n;
        pn_ooo   = ooo_pc_next;
        pn_ppl   = ppl_pc_next;
      end
      if (swap_done) begin
        latency = n;
        break;
      end
      step();
    end
    step();
  endtask

  initial begin
    int          lat, ldc, dones, first_done, second_done;
    logic [31:0] pn_o, pn_p;

    $display("[TB] start");
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check_output("reset_swap_count", 32'(swap_count),    32'h0);
    check_output("reset_thread",     32'(thread_on_ooo), 32'h0);
    check_output("reset_busy",       32'(swap_busy),     32'h0);

    // Single swap with distinct patterns and PCs.
    reload_files();
    ooo_pc = 32'h80;
    ppl_pc = 32'h400;
    apply_stimulus(lat, ldc, pn_o, pn_p);
    check_output("single_latency",     32'(lat), 32'd34);
    check_output("single_redir_cycle", 32'(ldc), 32'd33);
    check_output("single_ooo_pc_next", pn_o, 32'h400);
    check_output("single_ppl_pc_next", pn_p, 32'h80);
    for (int i = 1; i < NUM_REGS; i++) begin
      check_output("single_ooo_reg", ooo_mem[i], 32'(32'h2000 + i));
      check_output("single_ppl_reg", ppl_mem[i], 32'(32'h1000 + i));
    end
    check_output("x0_ooo", ooo_mem[0], 32'hDEAD);
    check_output("x0_ppl", ppl_mem[0], 32'hDEAD);
    check_output("single_thread", 32'(thread_on_ooo), 32'h1);
    check_output("single_count",  32'(swap_count),    32'h1);

    // Request held through cycles 0..40: second swap must start at cycle 35.
    rst = 1'b1;
    step();
    rst = 1'b0;
    reload_files();
    dones       = 0;
    first_done  = -1;
    second_done = -1;
    swap_req    = 1'b1;
    for (int n = 0; n <= 80; n++) begin
      @(negedge clk);
      if (swap_done) begin
        if (first_done < 0) first_done = n;
        else                second_done = n;
        dones++;
      end
      step();
      if (n == 40) swap_req = 1'b0;
    end
    check_output("held_done_pulses", 32'(dones),       32'd2);
    check_output("held_first_done",  32'(first_done),  32'd34);
    check_output("held_second_done", 32'(second_done), 32'd69);
    check_output("held_count",       32'(swap_count),  32'h2);
    check_output("held_thread",      32'(thread_on_ooo), 32'h0);
    for (int i = 1; i < NUM_REGS; i++) begin
      check_output("held_ooo_reg", ooo_mem[i], 32'(32'h1000 + i));
      check_output("held_ppl_reg", ppl_mem[i], 32'(32'h2000 + i));
    end

    // Reset in cycle 10 of a swap.
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    check_output("midrst_busy",  32'(swap_busy),   32'h0);
    check_output("midrst_stall", 32'(stall_cores), 32'h0);
    check_output("midrst_we",    32'({ooo_rf_we, ppl_rf_we}), 32'h0);
    check_output("midrst_count", 32'(swap_count),  32'h0);
    rst = 1'b0;
    step();

    // Three back-to-back swaps alternate the thread on the OOO core.
    reload_files();
    apply_stimulus(lat, ldc, pn_o, pn_p);
    check_output("alt1_latency", 32'(lat), 32'd34);
    check_output("alt1_thread",  32'(thread_on_ooo), 32'h1);
    apply_stimulus(lat, ldc, pn_o, pn_p);
    check_output("alt2_latency", 32'(lat), 32'd34);
    check_output("alt2_thread",  32'(thread_on_ooo), 32'h0);
    apply_stimulus(lat, ldc, pn_o, pn_p);
    check_output("alt3_latency", 32'(lat), 32'd34);
    check_output("alt3_thread",  32'(thread_on_ooo), 32'h1);
    check_output("alt_count",    32'(swap_count),    32'h3);

    // Counter saturation from a preloaded all-ones value.
    preload_count = 1'b1;
    @(posedge clk);
    force dut.swap_count_q = 16'hFFFF;
    #2;
    preload_count = 1'b0;
    step();
    release dut.swap_count_q;
    step();
    check_output("sat_preload", 32'(swap_count), 32'hFFFF);
    apply_stimulus(lat, ldc, pn_o, pn_p);
    check_output("sat_latency", 32'(lat), 32'd34);
    check_output("sat_count",   32'(swap_count), 32'hFFFF);
    check_output("sat_thread",  32'(thread_on_ooo), 32'h0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
